fir_coef_loader: RTL and testbench

//   Coefficient controller for the FIR tap datapath. Accepts a serial stream of

---
 rtl/fir_coef_loader.sv | 131 +++++++++++++
 tb/tb_fir_coef_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: streams TAPS coefficients into a shadow bank, swaps the whole
// bank onto the FIR coefficient bus in one cycle, then times out the FIR pipeline fill.
module fir_coef_loader #(
    parameter int CWIDTH     = 16,
    parameter int TAPS       = 16,
    parameter int SETTLE_CYC = TAPS + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   abort,
    input  logic                   coef_valid,
    input  logic [CWIDTH-1:0]      coef_data,
    output logic                   coef_ready,
    output logic [TAPS*CWIDTH-1:0] coefs,
    output logic                   busy,
    output logic                   swap_done,
    output logic                   settled
);

    localparam int IDX_W = $clog2(TAPS);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SWAP,
        S_SETTLE
    } state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         index_q;
    logic [IDX_W-1:0]         index_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [CWIDTH-1:0]        shadow_q [TAPS];
    logic [TAPS*CWIDTH-1:0]   coefs_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     swap_q;
    logic                     settled_q;
    logic                     beat;
    logic                     last_beat;

    assign beat      = coef_valid && ready_q;
    assign last_beat = beat && (index_q == LAST_IDX);
    assign index_d   = index_q + 1'b1;
    assign cnt_d     = cnt_q - 1'b1;

    // NOTE: every register here, the shadow bank included, uses non-blocking
    // assignment and is cleared by reset, so a reset mid-load leaves no stale taps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            cnt_q     <= '0;
            shadow_q  <= '{default: '0};
            coefs_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            swap_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            swap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        state_q <= S_LOAD;
                        index_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // Abort outranks a coincident beat: that word is neither stored nor counted.
                    if (abort) begin
                        state_q <= S_IDLE;
                        index_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (beat) begin
                        shadow_q[index_q] <= coef_data;
                        if (last_beat) begin
                            state_q <= S_SWAP;
                            index_q <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            index_q <= index_d;
                        end
                    end
                end

                S_SWAP: begin
                    for (int i = 0; i < TAPS; i++) begin
                        coefs_q[(TAPS-1-i)*CWIDTH +: CWIDTH] <= shadow_q[i];
                    end
                    swap_q    <= 1'b1;
                    settled_q <= 1'b0;
                    cnt_q     <= CNT_INIT;
                    state_q   <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        settled_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coef_ready = ready_q;
    assign coefs      = coefs_q;
    assign busy       = busy_q;
    assign swap_done  = swap_q;
    assign settled    = settled_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: control-vector table, directed multi-cycle
// sequences, and random traffic, all compared every cycle against a transaction-level model.
module tb_fir_coef_loader;

    localparam int CW = 16;
    localparam int T  = 16;
    localparam int S  = T + 2;
    localparam int BW = T * CW;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          abort;
    logic          coef_valid;
    logic [CW-1:0] coef_data;
    logic          coef_ready;
    logic [BW-1:0] coefs;
    logic          busy;
    logic          swap_done;
    logic          settled;

    int n_checks = 0;
    int n_err    = 0;

    fir_coef_loader #(.CWIDTH(CW), .TAPS(T), .SETTLE_CYC(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .abort     (abort),
        .coef_valid(coef_valid),
        .coef_data (coef_data),
        .coef_ready(coef_ready),
        .coefs     (coefs),
        .busy      (busy),
        .swap_done (swap_done),
        .settled   (settled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout required finish");
        $fatal(1);
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a list of accepted words; a swap starts a fill timer.
    bit            m_loading;
    bit            m_pend;
    int            m_remain;
    bit            m_settled;
    bit            m_swap;
    logic [BW-1:0] m_bank;
    logic [CW-1:0] m_words[$];

    function automatic void model_reset();
        m_loading = 1'b0;
        m_pend    = 1'b0;
        m_remain  = 0;
        m_settled = 1'b0;
        m_swap    = 1'b0;
        m_bank    = '0;
        m_words.delete();
    endfunction

    function automatic void model_edge();
        m_swap = 1'b0;
        if (m_loading) begin
            if (abort) begin
                m_loading = 1'b0;
                m_words.delete();
            end else if (coef_valid) begin
                m_words.push_back(coef_data);
                if (m_words.size() == T) begin
                    m_loading = 1'b0;
                    m_pend    = 1'b1;
                end
            end
        end else if (m_pend) begin
            for (int i = 0; i < T; i++) m_bank[(T-1-i)*CW +: CW] = m_words[i];
            m_words.delete();
            m_pend    = 1'b0;
            m_swap    = 1'b1;
            m_settled = 1'b0;
            m_remain  = S;
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) m_settled = 1'b1;
        end else if (load_start) begin
            m_loading = 1'b1;
        end
    endfunction

    task automatic compare_all();
        check_bit("coef_ready", coef_ready, m_loading);
        check_bit("busy", busy, m_loading || m_pend || (m_remain > 0));
        check_bit("swap_done", swap_done, m_swap);
        check_bit("settled", settled, m_settled);
        check_vec("coefs", coefs, m_bank);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asserted between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        abort      = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        model_reset();
        #1;
        compare_all();
        check_vec("rst_coefs", coefs, '0);
        check_bit("rst_ready", coef_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [CW-1:0] vals[T];

    function automatic logic [BW-1:0] pack_vals();
        logic [BW-1:0] r;
        for (int i = 0; i < T; i++) r[(T-1-i)*CW +: CW] = vals[i];
        return r;
    endfunction

    task automatic stream(input bit gaps);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (gaps) begin
                coef_valid = 1'b0;
                coef_data  = 16'hDEAD;
                step();
                check_bit("ready_in_gap", coef_ready, 1'b1);
            end
            coef_valid = 1'b1;
            coef_data  = vals[i];
            step();
        end
        coef_valid = 1'b0;
    endtask

    // Entered right after the last beat's edge E.
    task automatic run_swap_settle(input bit poke);
        check_bit("swap_not_yet", swap_done, 1'b0);
        step();
        check_bit("swap_pulse", swap_done, 1'b1);
        check_vec("bank_swapped", coefs, pack_vals());
        for (int k = 2; k <= S + 1; k++) begin
            if (poke) begin
                load_start = (k == 5) || (k == 10);
                abort      = (k == 5) || (k == 7);
            end
            step();
            load_start = 1'b0;
            abort      = 1'b0;
            if (k == 2) check_bit("swap_cleared", swap_done, 1'b0);
            check_bit("settled_timing", settled, k == S + 1);
            check_bit("busy_timing", busy, k != S + 1);
        end
    endtask

    typedef struct {
        bit            ls;
        bit            ab;
        bit            cv;
        logic [CW-1:0] d;
        bit            e_ready;
        bit            e_busy;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [BW-1:0] old_bank;
        logic [CW-1:0] xh[T];
        int            y;

        vt[0] = '{ls:0, ab:0, cv:1, d:16'h0007, e_ready:0, e_busy:0};
        vt[1] = '{ls:1, ab:0, cv:0, d:16'h0000, e_ready:1, e_busy:1};
        vt[2] = '{ls:1, ab:0, cv:0, d:16'h0000, e_ready:1, e_busy:1};
        vt[3] = '{ls:0, ab:0, cv:1, d:16'h0055, e_ready:1, e_busy:1};
        vt[4] = '{ls:0, ab:1, cv:1, d:16'h0066, e_ready:0, e_busy:0};
        vt[5] = '{ls:0, ab:1, cv:0, d:16'h0000, e_ready:0, e_busy:0};
        vt[6] = '{ls:1, ab:0, cv:0, d:16'h0000, e_ready:1, e_busy:1};
        vt[7] = '{ls:0, ab:1, cv:0, d:16'h0000, e_ready:0, e_busy:0};

        do_reset();

        foreach (vt[i]) begin
            load_start = vt[i].ls;
            abort      = vt[i].ab;
            coef_valid = vt[i].cv;
            coef_data  = vt[i].d;
            step();
            check_bit("vec_ready", coef_ready, vt[i].e_ready);
            check_bit("vec_busy", busy, vt[i].e_busy);
        end
        load_start = 1'b0;
        abort      = 1'b0;
        coef_valid = 1'b0;

        // Back-to-back stream 1..16.
        for (int i = 0; i < T; i++) vals[i] = CW'(i + 1);
        stream(1'b0);
        run_swap_settle(1'b0);
        check_vec("tap0_msb", BW'(coefs[BW-1 -: CW]), BW'(16'd1));
        check_vec("tap15_lsb", BW'(coefs[CW-1:0]), BW'(16'd16));

        // Gapped stream of -1..-16.
        for (int i = 0; i < T; i++) vals[i] = CW'(-(i + 1));
        stream(1'b1);
        run_swap_settle(1'b0);
        for (int i = 0; i < T; i++)
            check_vec("neg_tap", BW'(coefs[(T-1-i)*CW +: CW]), BW'(vals[i]));

        // Abort after five words, with a coincident valid word.
        old_bank   = pack_vals();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            coef_valid = 1'b1;
            coef_data  = CW'(16'h0AA0 + i);
            step();
        end
        abort      = 1'b1;
        coef_data  = 16'hBEEF;
        step();
        abort      = 1'b0;
        coef_valid = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_settled", settled, 1'b1);
        check_vec("abort_bank", coefs, old_bank);
        repeat (4) step();
        for (int i = 0; i < T; i++) vals[i] = CW'(100 + i);
        stream(1'b0);
        run_swap_settle(1'b0);
        for (int i = 0; i < T; i++)
            check_vec("reload_tap", BW'(coefs[(T-1-i)*CW +: CW]), BW'(vals[i]));

        // Control pulses during SETTLE are ignored; a later load_start is honoured.
        for (int i = 0; i < T; i++) vals[i] = CW'(16'h3000 + 3 * i);
        stream(1'b0);
        run_swap_settle(1'b1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check_bit("post_settle_load", coef_ready, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_bit("settled_kept", settled, 1'b1);

        // Asynchronous reset mid-stream and mid-SETTLE.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coef_valid = 1'b1;
            coef_data  = CW'(i + 9);
            step();
        end
        do_reset();
        for (int i = 0; i < T; i++) vals[i] = CW'($urandom);
        stream(1'b0);
        step();
        repeat (4) step();
        do_reset();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_settled", settled, 1'b0);

        // Impulse through a direct-form FIR driven from the coefs bus.
        for (int i = 0; i < T; i++) vals[i] = CW'($urandom);
        stream(1'b0);
        run_swap_settle(1'b0);
        for (int i = 0; i < T; i++) xh[i] = '0;
        for (int n = 0; n < T; n++) begin
            for (int k = T - 1; k > 0; k--) xh[k] = xh[k-1];
            xh[0] = (n == 0) ? CW'(1) : CW'(0);
            y = 0;
            for (int k = 0; k < T; k++)
                y += int'($signed(coefs[(T-1-k)*CW +: CW])) * int'($signed(xh[k]));
            check_int("fir_impulse", y, int'($signed(vals[n])));
            step();
        end
        check_bit("fir_settled", settled, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            load_start = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            coef_valid = ($urandom_range(0, 9) < 7);
            coef_data  = CW'($urandom);
            step();
        end
        load_start = 1'b0;
        abort      = 1'b0;
        coef_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
